fetch_unit: RTL
===============

# fetch_unit

Instruction-fetch stage of the 16-bit pipelined core. It owns the PC and the IF/ID instruction register, and presents instructions to the decode/control stage. It acts on that stage's PC-steering signals (PC_SEL, PC_BJ_RF, PC_Br_Jmp, PC_HOLD, smart stall). It computes branch and jump targets, inserts NOP bubbles on flush or hold, and sequences the single-instruction EXEC detour with automatic return.

## Interface
- `ADDR_W`, default 16: PC / instruction-address width.
- `NOP`, default 16'h0000: bubble instruction (ADD R0,R0,R0).
- `clk`  in  1: core clock, all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `smart`  in  1: hazard stall. Hold PC and instr_out.
- `pc_sel`  in  1: sel[0]. 1 = redirect PC to the computed target.
- `pc_bj_rf`  in  1: sel[1]. Redirect source: 0 = PC-relative, 1 = rf_target.
- `pc_br_jmp`  in  1: sel[2]. PC-relative offset: 0 = branch imm8, 1 = jump imm12.
- `pc_hold`  in  1: sel[9]. Freeze PC and issue NOP.
- `rf_target`  in  16: register-file value for JR/EXEC.
- `imem_rdata`  in  16: instruction memory data, combinational from imem_addr.
- `imem_addr`  out  ADDR_W: equals the PC register.
- `instr_out`  out  16: IF/ID instruction, the control-stage input.
- `pc_out`  out  ADDR_W: address of instr_out.
- `link_pc`  out  ADDR_W: ex_pc+1, the JAL link value.
- `exec_active`  out  1: high while in state EXEC_TGT.

## Operation
- Internal registers:
  - `pc`.
  - `instr_out`, `pc_out` (IF/ID).
  - `ex_instr`, `ex_pc`: copy of the IF/ID pair one stage later (EX). Loaded whenever IF/ID advances; loaded with NOP on flush.
  - `ret_pc`.
  - 2-state FSM {RUN, EXEC_TGT}.
- Target generation:
  - branch: ex_pc + 1 + sext(ex_instr[7:0]).
  - jump: ex_pc + 1 + sext(ex_instr[11:0]).
  - register: rf_target.
  - Arithmetic is modulo 2^ADDR_W; wrap at 16'hFFFF → 0 is legal.
- Per-cycle priority, highest first:
  1. `pc_sel`=1 (redirect): pc ← target; instr_out ← NOP; FSM → RUN unless the EXEC entry rule applies. Overrides smart and pc_hold.
  2. `smart`=1: all registers hold.
  3. `pc_hold`=1: pc holds; instr_out ← NOP; pc_out holds.
  4. Else: pc ← pc+1; instr_out ← imem_rdata; pc_out ← pc.
- EXEC entry: redirect with pc_bj_rf=1 and ex_instr[15:12]==`EXEC:
  - ret_pc ← ex_pc+1.
  - pc ← rf_target.
  - FSM → EXEC_TGT.
- EXEC_TGT advance cycle (no smart, no pc_sel):
  - instr_out ← imem_rdata, except when imem_rdata[15:14]==2'b11 (control-flow, including nested EXEC), where instr_out ← NOP.
  - pc ← ret_pc.
  - FSM → RUN.
- EXEC_TGT with smart: stay in EXEC_TGT. With pc_sel: normal redirect, EXEC abandoned, FSM → RUN.

## Timing
- Reset values: pc=0, imem_addr=0, instr_out=NOP, pc_out=0, ex_instr=NOP, ex_pc=0, ret_pc=0, link_pc=1, FSM=RUN, exec_active=0.
- Reset assertion mid-EXEC or mid-stall clears all state immediately. The first fetch after deassertion is address 0.
- Fetch latency: an instruction at address A appears on instr_out 1 cycle after pc==A.
- Redirect penalty: exactly 1 NOP bubble in instr_out. The target instruction appears 2 cycles after the pc_sel edge.
- EXEC cost:
  - redirect bubble, then the target instruction, then the instruction at ret_pc.
  - exec_active is high exactly one cycle absent stalls.
- Inputs are sampled only at the rising edge. Outputs are registered, except imem_addr (=pc) and link_pc (combinational from ex_pc).

## Configuration
- `FETCH_EXEC_EN` defined: EXEC FSM, ret_pc and exec_active are built as above.
- Not defined:
  - EXEC behaves as plain JR: redirect to rf_target with no return.
  - FSM and ret_pc are removed; exec_active is tied 0.
  - No control-flow filtering of the fetched target.

## Structure
- Opcode constants (`EXEC`, `JR`, `JAL`, `B`) and NOP come from the shared define.v; no local opcode literals.
- One sub-module: `pc_target_gen`, purely combinational. It takes ex_pc, ex_instr, rf_target, pc_bj_rf and pc_br_jmp, and outputs target.

## Test plan
- Reset, release, imem holds addr → data=addr|16'h1000 → instr_out=16'h1000,16'h1001,… with pc_out=0,1,…; mid-run rst low → pc=0, instr_out=NOP same instant.
- Branch: ex_pc=16'h0010, ex_instr imm8=8'hFE, pc_sel=1, pc_br_jmp=0 → pc=16'h000F; next instr_out=NOP, then mem[0x000F].
- smart=1 for 3 cycles with pc=5 → pc, instr_out, pc_out frozen; pc_sel and smart asserted together → redirect wins.
- pc_hold=1 at pc=8 → pc stays 8, instr_out=NOP each cycle; release → mem[8] next.
- EXEC at ex_pc=0x20, rf_target=0x80, mem[0x80]=ADD → exec_active 1 cycle, instr_out=NOP, ADD, mem[0x21].
- EXEC with mem[0x80] opcode 4'b11xx → NOP issued, return to 0x21. pc wrap: pc=16'hFFFF advance → 0.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: opcodes, bubble instruction, FSM states and control-flow classifier for the fetch stage
package fetch_unit_pkg;

    localparam logic [3:0]  OP_B      = 4'hC;
    localparam logic [3:0]  OP_JAL    = 4'hD;
    localparam logic [3:0]  OP_JR     = 4'hE;
    localparam logic [3:0]  OP_EXEC   = 4'hF;
    localparam logic [15:0] NOP_INSTR = 16'h0000;

    typedef enum logic {
        RUN,
        EXEC_TGT
    } fetch_state_e;

    // The control-flow opcodes are exactly the 2'b11 class, so nested EXEC is covered too
    function automatic logic is_ctrl_flow(input logic [3:0] op);
        return op inside {OP_B, OP_JAL, OP_JR, OP_EXEC};
    endfunction

endpackage

// File: rtl/pc_target_gen.sv
// pc_target_gen: combinational branch / jump / register PC target generation
module pc_target_gen
#(
    parameter int ADDR_W = 16
) (
    input  logic [ADDR_W-1:0] ex_pc,
    input  logic [11:0]       ex_instr,
    input  logic [15:0]       rf_target,
    input  logic              pc_bj_rf,
    input  logic              pc_br_jmp,
    output logic [ADDR_W-1:0] target
);

    logic [ADDR_W-1:0] offset;

    assign offset = pc_br_jmp ? {{(ADDR_W-12){ex_instr[11]}}, ex_instr[11:0]}
                              : {{(ADDR_W-8){ex_instr[7]}}, ex_instr[7:0]};
    assign target = pc_bj_rf ? ADDR_W'(rf_target) : ex_pc + ADDR_W'(1) + offset;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, IF/ID register, redirect/stall/hold handling and EXEC detour (EXEC FSM built when FETCH_EXEC_EN is defined)
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int          ADDR_W = 16,
    parameter logic [15:0] NOP    = NOP_INSTR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              smart,
    input  logic              pc_sel,
    input  logic              pc_bj_rf,
    input  logic              pc_br_jmp,
    input  logic              pc_hold,
    input  logic [15:0]       rf_target,
    input  logic [15:0]       imem_rdata,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       instr_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] link_pc,
    output logic              exec_active
);

    logic [ADDR_W-1:0] pc_q, pc_d, pc_out_q, pc_out_d, ex_pc_q, ex_pc_d;
    logic [15:0]       instr_q, instr_d, ex_instr_q, ex_instr_d;
    logic [ADDR_W-1:0] target, next_seq;
    logic [15:0]       fetched;
    logic              in_exec;

    pc_target_gen #(.ADDR_W(ADDR_W)) u_tgt (
        .ex_pc     (ex_pc_q),
        .ex_instr  (ex_instr_q[11:0]),
        .rf_target (rf_target),
        .pc_bj_rf  (pc_bj_rf),
        .pc_br_jmp (pc_br_jmp),
        .target    (target)
    );

    assign imem_addr = pc_q;
    assign instr_out = instr_q;
    assign pc_out    = pc_out_q;
    assign link_pc   = ex_pc_q + ADDR_W'(1);
    assign fetched   = (in_exec && is_ctrl_flow(imem_rdata[15:12])) ? NOP : imem_rdata;

`ifdef FETCH_EXEC_EN
    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] ret_pc_q, ret_pc_d;
    logic              exec_entry;

    assign in_exec     = state_q == EXEC_TGT;
    assign exec_active = in_exec;
    assign exec_entry  = pc_sel && pc_bj_rf && ex_instr_q[15:12] == OP_EXEC;
    assign next_seq    = in_exec ? ret_pc_q : pc_q + ADDR_W'(1);

    // EXEC detour: enter on an EXEC redirect, leave after one advance or on any redirect
    always_comb begin
        state_d  = state_q;
        ret_pc_d = ret_pc_q;
        if (exec_entry) begin
            state_d  = EXEC_TGT;
            ret_pc_d = link_pc;
        end else if (pc_sel || !smart) begin
            state_d = RUN;
        end
    end

    // EXEC state and return address register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= RUN;
            ret_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            ret_pc_q <= ret_pc_d;
        end
    end
`else
    logic unused_ex_op;

    assign in_exec      = 1'b0;
    assign exec_active  = 1'b0;
    assign next_seq     = pc_q + ADDR_W'(1);
    assign unused_ex_op = ^ex_instr_q[15:12];
`endif

    // Next PC / IF/ID / EX: redirect beats stall, stall beats hold, hold beats sequential fetch
    always_comb begin
        pc_d       = pc_q;
        instr_d    = instr_q;
        pc_out_d   = pc_out_q;
        ex_instr_d = ex_instr_q;
        ex_pc_d    = ex_pc_q;
        if (pc_sel) begin
            pc_d       = target;
            instr_d    = NOP;
            ex_instr_d = NOP;
            ex_pc_d    = pc_out_q;
        end else if (!smart) begin
            ex_instr_d = instr_q;
            ex_pc_d    = pc_out_q;
            if (in_exec || !pc_hold) begin
                pc_d     = next_seq;
                instr_d  = fetched;
                pc_out_d = pc_q;
            end else begin
                instr_d = NOP;
            end
        end
    end

    // PC, IF/ID and EX pipeline registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q       <= '0;
            instr_q    <= NOP;
            pc_out_q   <= '0;
            ex_instr_q <= NOP;
            ex_pc_q    <= '0;
        end else begin
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pc_out_q   <= pc_out_d;
            ex_instr_q <= ex_instr_d;
            ex_pc_q    <= ex_pc_d;
        end
    end

endmodule
